// File: rtl/fixed_softplus_2_if.sv
// rtl/fixed_softplus_2_if.sv - lane-bundle stream interface for the softplus stage
//
// Purpose: carries one beat of LANES parallel words plus its valid/ready handshake.
// Signals:
//   data   [LANES][WIDTH]  lane words, lane 0 in the least significant slot
//   valid                  beat is present (driven by master)
//   ready                  beat is accepted (driven by slave)
interface fixed_softplus_2_if #(
  parameter int LANES = 1,
  parameter int WIDTH = 16
);
  logic [LANES-1:0][WIDTH-1:0] data;
  logic                        valid;
  logic                        ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fixed_softplus_2.sv
// rtl/fixed_softplus_2.sv - two-stage fixed-point softplus y = ln(1 + e^x) over a lane bundle
//
// Purpose: y = max(x,0) + c(|x|), with c(t) = ln(1 + e^-t) read from a ROM built at elaboration.
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   data_in_0   slave stream, N signed lanes of DATA_IN_0_PRECISION_0 bits, FIN fraction bits
//   data_out_0  master stream, N signed lanes of DATA_OUT_0_PRECISION_0 bits, FOUT fraction bits
module fixed_softplus_2 #(
  parameter int DATA_IN_0_PRECISION_0        = 16,
  parameter int DATA_IN_0_PRECISION_1        = 1,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 1,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_1  = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1  = 1,
  parameter int DATA_OUT_0_PRECISION_0       = 32,
  parameter int DATA_OUT_0_PRECISION_1       = 1,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_0 = 1,
  parameter int DATA_OUT_0_TENSOR_SIZE_DIM_1 = 1,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_OUT_0_PARALLELISM_DIM_1 = 1,
  parameter int LUT_FRAC_BITS                = 2
) (
  input  logic               clk,
  input  logic               rst,
  fixed_softplus_2_if.slave  data_in_0,
  fixed_softplus_2_if.master data_out_0
);

  localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IW    = DATA_IN_0_PRECISION_0;
  localparam int FIN   = DATA_IN_0_PRECISION_1;
  localparam int OW    = DATA_OUT_0_PRECISION_0;
  localparam int FOUT  = DATA_OUT_0_PRECISION_1;
  localparam int SH    = FOUT - FIN;
  localparam int IDX_W = 3 + LUT_FRAC_BITS;
  localparam int ROM_N = 8 << LUT_FRAC_BITS;
  // Rescale |x| from FIN to LUT_FRAC_BITS fraction bits (only one of these is nonzero).
  localparam int ID_R  = (FIN >= LUT_FRAC_BITS) ? FIN - LUT_FRAC_BITS : 0;
  localparam int ID_L  = (FIN >= LUT_FRAC_BITS) ? 0 : LUT_FRAC_BITS - FIN;

  localparam logic [IW-1:0] MIN_IN  = {1'b1, {(IW-1){1'b0}}};
  localparam logic [IW-1:0] MAX_IN  = ~MIN_IN;
  localparam logic [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
  // |x| must be below 8.0 for the correction term to apply.
  localparam logic [63:0]   T_LIMIT = 64'd8 << FIN;

  // Correction ROM: round-half-up(ln(1 + e^-(k/2^LFB)) * 2^FOUT), folded at elaboration.
  function automatic logic [OW-1:0] rom_entry(input int k);
    real t;
    real v;
    t = real'(k) / real'(1 << LUT_FRAC_BITS);
    v = $ln(1.0 + $exp(-t)) * real'(longint'(1) << FOUT);
    return OW'(longint'($floor(v + 0.5)));
  endfunction

  logic [OW-1:0] rom [ROM_N];
  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    assign rom[k] = rom_entry(k);
  end

  logic                      v1_q, v2_q;
  logic [N-1:0][OW-1:0]      r1_d, r1_q;
  logic [N-1:0][IDX_W-1:0]   idx1_d, idx1_q;
  logic [N-1:0]              inr1_d, inr1_q;
  logic [N-1:0][OW-1:0]      y2_d, y2_q;
  logic [IW-1:0]             t_abs;
  logic [63:0]               t_wide;
  logic [OW:0]               sum;
  logic                      ld1, ld2;

  // A stage loads when empty or when its successor is taking its contents.
  assign ld2             = !v2_q || data_out_0.ready;
  assign ld1             = !v1_q || ld2;
  assign data_in_0.ready = ld1;

  assign data_out_0.valid = v2_q;
  assign data_out_0.data  = y2_q;

  // S1: positive part, saturated magnitude, ROM index and range flag.
  always_comb begin
    r1_d   = '0;
    idx1_d = '0;
    inr1_d = '0;
    t_abs  = '0;
    t_wide = '0;
    for (int i = 0; i < N; i++) begin
      if (data_in_0.data[i][IW-1]) begin
        r1_d[i] = '0;
        // Most negative input has no positive counterpart; clamp it.
        t_abs   = (data_in_0.data[i] == MIN_IN) ? MAX_IN : (~data_in_0.data[i] + 1'b1);
      end else begin
        // Non-negative, so zero extension equals sign extension.
        r1_d[i] = OW'(data_in_0.data[i]) << SH;
        t_abs   = data_in_0.data[i];
      end
      t_wide    = 64'(t_abs);
      inr1_d[i] = (t_wide < T_LIMIT);
      idx1_d[i] = IDX_W'((t_wide >> ID_R) << ID_L);
    end
  end

  // S2: add the correction (zero outside the table) and saturate at the positive limit.
  always_comb begin
    y2_d = '0;
    sum  = '0;
    for (int i = 0; i < N; i++) begin
      sum     = {1'b0, r1_q[i]} + {1'b0, (inr1_q[i] ? rom[idx1_q[i]] : {OW{1'b0}})};
      y2_d[i] = (sum > {1'b0, OUT_MAX}) ? OUT_MAX : sum[OW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      r1_q   <= '0;
      idx1_q <= '0;
      inr1_q <= '0;
      v2_q   <= 1'b0;
      y2_q   <= '0;
    end else begin
      if (ld1) begin
        v1_q <= data_in_0.valid;
        if (data_in_0.valid) begin
          r1_q   <= r1_d;
          idx1_q <= idx1_d;
          inr1_q <= inr1_d;
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          y2_q <= y2_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_softplus_2.sv
// tb/tb_fixed_softplus_2.sv - directed self-checking bench for fixed_softplus_2
module tb_fixed_softplus_2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fixed_softplus_2_if #(.LANES(1), .WIDTH(16)) in0  ();
  fixed_softplus_2_if #(.LANES(1), .WIDTH(32)) out0 ();
  fixed_softplus_2_if #(.LANES(1), .WIDTH(16)) in1  ();
  fixed_softplus_2_if #(.LANES(1), .WIDTH(32)) out1 ();
  fixed_softplus_2_if #(.LANES(4), .WIDTH(16)) in2  ();
  fixed_softplus_2_if #(.LANES(4), .WIDTH(32)) out2 ();

  fixed_softplus_2 u_def (.clk(clk), .rst(rst), .data_in_0(in0), .data_out_0(out0));

  fixed_softplus_2 #(.DATA_OUT_0_PRECISION_1(8)) u_f8 (
    .clk(clk), .rst(rst), .data_in_0(in1), .data_out_0(out1));

  fixed_softplus_2 #(
    .DATA_IN_0_PARALLELISM_DIM_0(4), .DATA_OUT_0_PARALLELISM_DIM_0(4)
  ) u_l4 (.clk(clk), .rst(rst), .data_in_0(in2), .data_out_0(out2));

  task automatic test_reset();
    rst = 1'b0;
    #12;
    checks++;
    if (out0.valid !== 1'b0 || out0.data !== 32'd0) begin
      errors++;
      $display("FAIL reset_def: valid=%b data=%0d, required valid=0 data=0", out0.valid, out0.data);
    end
    checks++;
    if (out1.valid !== 1'b0 || out1.data !== 32'd0) begin
      errors++;
      $display("FAIL reset_f8: valid=%b data=%0d, required valid=0 data=0", out1.valid, out1.data);
    end
    checks++;
    if (out2.valid !== 1'b0 || out2.data !== 128'd0) begin
      errors++;
      $display("FAIL reset_l4: valid=%b data=%h, required valid=0 data=0", out2.valid, out2.data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in0.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in0.ready);
    end
  endtask

  task automatic test_single();
    logic [15:0] xs [6];
    logic [31:0] ys [6];
    xs = '{16'hFFF8, 16'hFFFE, 16'h0000, 16'h0002, 16'h0008, 16'h0010};
    ys = '{32'd0, 32'd1, 32'd1, 32'd3, 32'd8, 32'd16};
    out0.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in0.data  = xs[i];
      in0.valid = 1'b1;
      checks++;
      if (in0.ready !== 1'b1) begin
        errors++;
        $display("FAIL single_ready[%0d]: got %b, required 1", i, in0.ready);
      end
      @(posedge clk);
      #1;
      in0.valid = 1'b0;
      checks++;
      if (out0.valid !== 1'b0) begin
        errors++;
        $display("FAIL single_early[%0d]: valid=%b one edge after accept, required 0", i, out0.valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out0.valid !== 1'b1 || out0.data !== ys[i]) begin
        errors++;
        $display("FAIL single[%0d] in=%h: valid=%b data=%0d, required valid=1 data=%0d",
                 i, xs[i], out0.valid, out0.data, ys[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out0.valid !== 1'b0) begin
        errors++;
        $display("FAIL single_drop[%0d]: valid=%b after handshake, required 0", i, out0.valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    real    model;
    real    diff;
    int     x;
    out0.ready = 1'b1;
    for (int cyc = 0; cyc < 19; cyc++) begin
      in0.valid = (cyc < 17);
      in0.data  = 16'(cyc - 8);
      @(posedge clk);
      #1;
      if (cyc >= 1 && cyc <= 17) begin
        x     = cyc - 1 - 8;
        model = $ln(1.0 + $exp(real'(x) / 2.0)) * 2.0;
        diff  = real'($signed(out0.data)) - model;
        checks++;
        if (out0.valid !== 1'b1 || diff > 1.0 || diff < -1.0) begin
          errors++;
          $display("FAIL sweep x=%0d: valid=%b data=%0d, required valid=1 data~%f", x, out0.valid,
                   $signed(out0.data), model);
        end
      end
    end
    in0.valid = 1'b0;
    checks++;
    if (out0.valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_tail: valid=%b, required 0", out0.valid);
    end
  endtask

  task automatic test_stall();
    out0.ready = 1'b0;
    in0.data   = 16'h0002;
    in0.valid  = 1'b1;
    @(posedge clk);
    #1;
    in0.valid = 1'b0;
    @(posedge clk);
    #1;
    in0.data  = 16'h0008;
    in0.valid = 1'b1;
    checks++;
    if (in0.ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_second_ready: got %b, required 1", in0.ready);
    end
    @(posedge clk);
    #1;
    in0.data = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (in0.ready !== 1'b0 || out0.valid !== 1'b1 || out0.data !== 32'd3) begin
        errors++;
        $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b data=%0d, required 0 1 3",
                 k, in0.ready, out0.valid, out0.data);
      end
      @(posedge clk);
      #1;
    end
    out0.ready = 1'b1;
    @(posedge clk);
    #1;
    in0.valid = 1'b0;
    checks++;
    if (out0.valid !== 1'b1 || out0.data !== 32'd8) begin
      errors++;
      $display("FAIL stall_second: valid=%b data=%0d, required valid=1 data=8", out0.valid, out0.data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out0.valid !== 1'b1 || out0.data !== 32'd1) begin
      errors++;
      $display("FAIL stall_third: valid=%b data=%0d, required valid=1 data=1", out0.valid, out0.data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out0.valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: valid=%b, required 0", out0.valid);
    end
  endtask

  task automatic test_fout8();
    logic [15:0] xs [3];
    logic [31:0] ys [3];
    xs = '{16'h0000, 16'h0002, 16'h7FFF};
    ys = '{32'd177, 32'd336, 32'd4194176};
    out1.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in1.data  = xs[i];
      in1.valid = 1'b1;
      @(posedge clk);
      #1;
      in1.valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out1.valid !== 1'b1 || out1.data !== ys[i]) begin
        errors++;
        $display("FAIL fout8[%0d] in=%h: valid=%b data=%0d, required valid=1 data=%0d",
                 i, xs[i], out1.valid, out1.data, ys[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_lanes();
    logic [31:0] ys [4];
    ys = '{32'd1, 32'd1, 32'd3, 32'd8};
    out2.ready = 1'b1;
    in2.data   = {16'h0008, 16'h0002, 16'h0000, 16'hFFFE};
    in2.valid  = 1'b1;
    @(posedge clk);
    #1;
    in2.valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out2.valid !== 1'b1 || out2.data[i] !== ys[i]) begin
        errors++;
        $display("FAIL lanes[%0d]: valid=%b data=%0d, required valid=1 data=%0d",
                 i, out2.valid, out2.data[i], ys[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    out0.ready = 1'b0;
    in0.data   = 16'h0004;
    in0.valid  = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in0.valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (out0.valid !== 1'b0 || out0.data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b data=%0d, required valid=0 data=0", out0.valid, out0.data);
    end
    @(negedge clk);
    rst        = 1'b1;
    out0.ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out0.valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_flush[%0d]: valid=%b, required 0", k, out0.valid);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    in0.data   = '0;
    in0.valid  = 1'b0;
    out0.ready = 1'b1;
    in1.data   = '0;
    in1.valid  = 1'b0;
    out1.ready = 1'b1;
    in2.data   = '0;
    in2.valid  = 1'b0;
    out2.ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fout8();
    test_lanes();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
